// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: redirect/stall bundle between the pipeline sources and the PC register
interface pc_ctrl_if #(parameter int ADDR_W = 32);
  logic              irq_jump_en_i;
  logic [ADDR_W-1:0] irq_jump_addr_i;
  logic              ex_jump_en_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  logic              div_hold_i;
  logic              bus_hold_i;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              hold_flag_o;
  logic              flush_o;
  logic              bus_err_o;
  modport slave (
    input  irq_jump_en_i, irq_jump_addr_i, ex_jump_en_i, ex_jump_addr_i, div_hold_i, bus_hold_i,
    output jump_en_o, jump_addr_o, hold_flag_o, flush_o, bus_err_o
  );
  modport master (
    output irq_jump_en_i, irq_jump_addr_i, ex_jump_en_i, ex_jump_addr_i, div_hold_i, bus_hold_i,
    input  jump_en_o, jump_addr_o, hold_flag_o, flush_o, bus_err_o
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: arbitrates PC redirects, merges stalls, buffers redirects across bus stalls
module pc_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input logic     clk,
  input logic     rst_n,
  pc_ctrl_if.slave pc
);
  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;
  localparam int WD_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] pend_addr, pend_nx, sel_addr, jump_addr;
  logic [WD_W-1:0]   wd_cnt;
  logic              take, jump_en, flush;
  assign sel_addr = pc.irq_jump_en_i ? pc.irq_jump_addr_i : pc.ex_jump_addr_i;
  // redirect FSM, flush counter and buffered target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_addr <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend_addr <= pend_nx;
    end
  end
  // next state and redirect decode; ex requests are only accepted from IDLE
  always_comb begin
    state_nx  = (state == FLUSH && cnt == 4'd1) ? IDLE : state;
    cnt_nx    = (state == FLUSH) ? cnt - 4'd1 : cnt;
    pend_nx   = pend_addr;
    jump_en   = 1'b0;
    jump_addr = '0;
    flush     = state != IDLE;
    take      = (state == IDLE) ? (pc.irq_jump_en_i | pc.ex_jump_en_i) : (state == FLUSH && pc.irq_jump_en_i);
    if (state == PEND) begin
      pend_nx = pc.irq_jump_en_i ? pc.irq_jump_addr_i : pend_addr;
      if (!pc.bus_hold_i) begin
        jump_en   = 1'b1;
        jump_addr = pc.irq_jump_en_i ? pc.irq_jump_addr_i : pend_addr;
      end
    end else if (take) begin
      flush = 1'b1;
      if (pc.bus_hold_i) begin
        state_nx = PEND;
        pend_nx  = sel_addr;
      end else begin
        jump_en   = 1'b1;
        jump_addr = sel_addr;
      end
    end
    if (jump_en) begin
      state_nx = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
      cnt_nx   = 4'(FLUSH_CYCLES - 1);
    end
  end
  // fetch-bus watchdog: counts consecutive stall cycles, saturating at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt <= '0;
    else        wd_cnt <= !pc.bus_hold_i ? '0 : (wd_cnt == WD_W'(TIMEOUT)) ? wd_cnt : wd_cnt + WD_W'(1);
  end
  assign pc.jump_en_o   = rst_n & jump_en;
  assign pc.jump_addr_o = rst_n ? jump_addr : '0;
  assign pc.flush_o     = rst_n & flush;
  assign pc.hold_flag_o = rst_n & !jump_en & (pc.div_hold_i | pc.bus_hold_i | state == PEND);
  assign pc.bus_err_o   = rst_n && TIMEOUT != 0 && pc.bus_hold_i && wd_cnt == WD_W'(TIMEOUT - 1);
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed vector table, reset-in-PEND sequence and randomized model check
module tb_pc_ctrl;
  localparam int FC = 2;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pc_ctrl_if #(.ADDR_W(32)) pif();
  pc_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(FC), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .pc(pif));
  always #5 clk = ~clk;
  typedef struct packed {logic jump; logic [31:0] addr; logic hold; logic flush; logic err;} out_t;
  typedef struct {
    logic rst; logic irq; logic [31:0] irq_a; logic ex; logic [31:0] ex_a; logic div; logic bus; out_t e;
  } vec_t;
  int checks = 0;
  int errors = 0;
  bit m_pend;
  logic [31:0] m_pa;
  int m_fl, m_run;
  vec_t tbl[$];
  function automatic vec_t v(bit irq, logic [31:0] ia, bit ex, logic [31:0] ea, bit div, bit bus,
                             bit j, logic [31:0] a, bit h, bit f, bit e);
    vec_t x;
    x.rst = 1'b1; x.irq = irq; x.irq_a = ia; x.ex = ex; x.ex_a = ea; x.div = div; x.bus = bus;
    x.e.jump = j; x.e.addr = a; x.e.hold = h; x.e.flush = f; x.e.err = e;
    return x;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic out_t model_out(vec_t x);
    out_t e = '0;
    bit take;
    take = !m_pend && (x.irq || (x.ex && m_fl == 0));
    if (x.rst) begin
      if (m_pend || take) begin
        e.flush = 1'b1;
        if (!x.bus) begin
          e.jump = 1'b1;
          e.addr = x.irq ? x.irq_a : (m_pend ? m_pa : x.ex_a);
        end
      end else e.flush = m_fl > 0;
      e.hold = !e.jump && (x.div || x.bus || m_pend);
      e.err  = x.bus && m_run == TO - 1;
    end
    return e;
  endfunction
  task automatic model_step(vec_t x);
    bit was, take;
    was  = m_pend;
    take = !m_pend && (x.irq || (x.ex && m_fl == 0));
    if (!x.rst) begin
      m_pend = 0; m_pa = '0; m_fl = 0; m_run = 0;
    end else begin
      if (was || take) begin
        if (x.bus) begin
          m_pend = 1;
          m_pa   = x.irq ? x.irq_a : (was ? m_pa : x.ex_a);
          m_fl   = 0;
        end else begin
          m_pend = 0;
          m_fl   = FC - 1;
        end
      end else if (m_fl > 0) m_fl--;
      m_run = x.bus ? (m_run < TO ? m_run + 1 : TO) : 0;
    end
  endtask
  task automatic cycle(vec_t x, bit use_model, string tag);
    out_t e;
    @(negedge clk);
    rst_n = x.rst;
    pif.irq_jump_en_i = x.irq; pif.irq_jump_addr_i = x.irq_a;
    pif.ex_jump_en_i = x.ex;   pif.ex_jump_addr_i = x.ex_a;
    pif.div_hold_i = x.div;    pif.bus_hold_i = x.bus;
    #1;
    e = use_model ? model_out(x) : x.e;
    chk({tag, " jump_en"}, {31'b0, pif.jump_en_o}, {31'b0, e.jump});
    chk({tag, " jump_addr"}, pif.jump_addr_o, e.addr);
    chk({tag, " hold_flag"}, {31'b0, pif.hold_flag_o}, {31'b0, e.hold});
    chk({tag, " flush"}, {31'b0, pif.flush_o}, {31'b0, e.flush});
    chk({tag, " bus_err"}, {31'b0, pif.bus_err_o}, {31'b0, e.err});
    @(posedge clk);
    model_step(x);
  endtask
  initial begin
    vec_t idle, r;
    bit bus;
    idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pif.irq_jump_en_i = 0; pif.irq_jump_addr_i = 0; pif.ex_jump_en_i = 0;
    pif.ex_jump_addr_i = 0; pif.div_hold_i = 0; pif.bus_hold_i = 0;
    m_pend = 0; m_pa = '0; m_fl = 0; m_run = 0;
    r = v(1, 32'h1234, 1, 32'h55, 1, 0, 0, 0, 0, 0, 0);
    r.rst = 0;
    cycle(r, 0, "reset_gate");
    r.bus = 1;
    cycle(r, 0, "reset_gate_bus");
    tbl.push_back(idle);
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(idle);
    tbl.push_back(v(0, 0, 1, 32'h100, 0, 0, 1, 32'h100, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 32'h104, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(v(1, 32'h8000_0000, 1, 32'h200, 0, 0, 1, 32'h8000_0000, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(v(0, 0, 1, 32'h300, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 32'h8000_0004, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h8000_0004, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle);
    for (int i = 0; i < 10; i++) tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, i == 3));
    tbl.push_back(idle);
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(idle);
    foreach (tbl[i]) cycle(tbl[i], 0, $sformatf("vec%0d", i));
    cycle(v(0, 0, 1, 32'h500, 0, 1, 0, 0, 1, 1, 0), 0, "pend_enter");
    cycle(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0), 0, "pend_wait");
    r = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    r.rst = 0;
    cycle(r, 0, "pend_reset");
    cycle(idle, 0, "pend_reset_release");
    cycle(idle, 0, "pend_reset_after");
    bus = 0;
    for (int i = 0; i < 3000; i++) begin
      bus = $urandom_range(0, 9) < (bus ? 8 : 2);
      r = v($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0, $urandom,
            $urandom_range(0, 3) == 0, bus, 0, 0, 0, 0, 0);
      r.rst = $urandom_range(0, 149) != 0;
      cycle(r, 1, $sformatf("rand%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
